// File: rtl/mem_port_ctrl_if.sv
// Bus bundles for mem_port_ctrl: the CPU-side request/response bus and the
// physical-memory bus. The controller is the slave of cpu_bus_if and the master of pmem_bus_if.
`timescale 1ns/1ps

interface cpu_bus_if;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [3:0]  mbe;
    logic [31:0] rdata;
    logic        resp;
    logic        err;

    modport master (
        output read, write, address, wdata, mbe,
        input  rdata, resp, err
    );

    modport slave (
        input  read, write, address, wdata, mbe,
        output rdata, resp, err
    );
endinterface

interface pmem_bus_if;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [3:0]  mbe;
    logic [31:0] rdata;
    logic        resp;

    modport master (
        output read, write, address, wdata, mbe,
        input  rdata, resp
    );

    modport slave (
        input  read, write, address, wdata, mbe,
        output rdata, resp
    );
endinterface

// File: rtl/mem_port_ctrl.sv
// Registered request/response bridge between the RV32I multicycle core and variable-latency memory.
// Optional REQ timeout is enabled by defining MEM_PORT_TIMEOUT_EN.
`timescale 1ns/1ps

module mem_port_ctrl #(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    cpu_bus_if.slave          cpu,
    pmem_bus_if.master        pmem,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [29:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         mbe_q, mbe_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               pmem_read_q, pmem_read_d;
    logic               pmem_write_q, pmem_write_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               timeout_hit;

    function automatic logic mbe_legal(input logic [3:0] mbe);
        case (mbe)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: mbe_legal = 1'b1;
            default:                   mbe_legal = 1'b0;
        endcase
    endfunction

`ifdef MEM_PORT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] timeout_q, timeout_d;

    // Counter sits at zero outside REQ, so it is already clear on REQ entry.
    assign timeout_hit = (timeout_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        timeout_d = '0;
        if (state_q == REQ) begin
            timeout_d = timeout_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_q <= '0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mbe_d        = mbe_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        pmem_read_d  = pmem_read_q;
        pmem_write_d = pmem_write_q;
        stall_d      = stall_q;

        case (state_q)
            IDLE: begin
                if (cpu.read && cpu.write) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end else if (cpu.read) begin
                    addr_d      = cpu.address[31:2];
                    wdata_d     = cpu.wdata;
                    mbe_d       = 4'hF;
                    pmem_read_d = 1'b1;
                    state_d     = REQ;
                end else if (cpu.write) begin
                    if (mbe_legal(cpu.mbe)) begin
                        addr_d       = cpu.address[31:2];
                        wdata_d      = cpu.wdata;
                        mbe_d        = cpu.mbe;
                        pmem_write_d = 1'b1;
                        state_d      = REQ;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = DONE;
                    end
                end
            end

            REQ: begin
                if (stall_q != '1) begin
                    stall_d = stall_q + CNT_W'(1);
                end
                // A response landing on the timeout cycle still counts as a normal completion.
                if (pmem.resp) begin
                    rdata_d      = pmem_write_q ? 32'h0 : pmem.rdata;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    state_d      = DONE;
                end else if (timeout_hit) begin
                    rdata_d      = '0;
                    err_d        = 1'b1;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    state_d      = DONE;
                end
            end

            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            mbe_q        <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            stall_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mbe_q        <= mbe_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
            stall_q      <= stall_d;
        end
    end

    assign cpu.rdata    = rdata_q;
    assign cpu.resp     = (state_q == DONE);
    assign cpu.err      = err_q;
    assign pmem.read    = pmem_read_q;
    assign pmem.write   = pmem_write_q;
    assign pmem.address = {addr_q, 2'b00};
    assign pmem.wdata   = wdata_q;
    assign pmem.mbe     = mbe_q;
    assign stall_count  = stall_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl: table of single transactions plus hand sequences for
// reset, back-to-back, stray responses, counter saturation and (with MEM_PORT_TIMEOUT_EN) timeout.
`timescale 1ns/1ps

module tb_mem_port_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] stall_count;
    logic [3:0]  stall_small;

    always #5 clk = ~clk;

    cpu_bus_if  cpu();
    pmem_bus_if pmem();
    cpu_bus_if  cpu_s();
    pmem_bus_if pmem_s();

    mem_port_ctrl #(.CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu         (cpu),
        .pmem        (pmem),
        .stall_count (stall_count)
    );

    // Narrow-counter copy sees the same stimulus so saturation can be observed.
    mem_port_ctrl #(.CNT_W(4)) dut_small (
        .clk         (clk),
        .rst         (rst),
        .cpu         (cpu_s),
        .pmem        (pmem_s),
        .stall_count (stall_small)
    );

    assign cpu_s.read    = cpu.read;
    assign cpu_s.write   = cpu.write;
    assign cpu_s.address = cpu.address;
    assign cpu_s.wdata   = cpu.wdata;
    assign cpu_s.mbe     = cpu.mbe;
    assign pmem_s.rdata  = pmem.rdata;
    assign pmem_s.resp   = pmem.resp;

`ifdef MEM_PORT_TIMEOUT_EN
    cpu_bus_if   cpu_t();
    pmem_bus_if  pmem_t();
    logic [31:0] stall_t;

    mem_port_ctrl #(.CNT_W(32), .TIMEOUT_CYCLES(4)) dut_to (
        .clk         (clk),
        .rst         (rst),
        .cpu         (cpu_t),
        .pmem        (pmem_t),
        .stall_count (stall_t)
    );
`endif

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mbe;
        int          wait_cyc;
        logic [31:0] mem_data;
        logic        exp_rd;
        logic        exp_wr;
        logic [31:0] exp_addr;
        logic [3:0]  exp_mbe;
        int          exp_lat;
        int          exp_req;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        vecs[12];
    int          checks = 0;
    int          fails  = 0;
    logic [31:0] exp_stall = 0;

    function automatic logic [31:0] sat15(input logic [31:0] v);
        return (v > 32'd15) ? 32'd15 : v;
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        cpu.read    = v.rd;
        cpu.write   = v.wr;
        cpu.address = v.addr;
        cpu.wdata   = v.wdata;
        cpu.mbe     = v.mbe;
        pmem.rdata  = v.mem_data;
        pmem.resp   = 1'b0;
    endtask

    task automatic check_output(input int idx, input vec_t v, input int resp_cyc,
                                input logic got_err, input logic [31:0] got_rdata,
                                input int req_cyc, input logic snap_rd, input logic snap_wr,
                                input logic [31:0] snap_addr, input logic [3:0] snap_mbe,
                                input logic [31:0] snap_wdata, input logic stable,
                                input logic post_resp, input logic [31:0] post_rdata);
        string tag;
        tag = $sformatf("vec%0d", idx);
        check_val({tag, " latency"}, resp_cyc, v.exp_lat);
        check_val({tag, " cpu_err"}, got_err, v.exp_err);
        check_val({tag, " cpu_rdata"}, got_rdata, v.exp_rdata);
        check_val({tag, " req_cycles"}, req_cyc, v.exp_req);
        if (v.exp_req > 0) begin
            check_val({tag, " pmem_read"}, snap_rd, v.exp_rd);
            check_val({tag, " pmem_write"}, snap_wr, v.exp_wr);
            check_val({tag, " pmem_address"}, snap_addr, v.exp_addr);
            check_val({tag, " pmem_mbe"}, snap_mbe, v.exp_mbe);
            check_val({tag, " pmem_stable"}, stable, 1'b1);
            if (v.exp_wr) begin
                check_val({tag, " pmem_wdata"}, snap_wdata, v.wdata);
            end
        end
        check_val({tag, " resp_pulse_end"}, post_resp, 1'b0);
        check_val({tag, " rdata_hold"}, post_rdata, v.exp_rdata);
        check_val({tag, " stall_count"}, stall_count, exp_stall);
        check_val({tag, " stall_small"}, 32'(stall_small), sat15(exp_stall));
    endtask

    task automatic run_vector(input int idx, input vec_t v);
        int          resp_cyc = -1;
        int          req_cyc  = 0;
        logic        stable   = 1'b1;
        logic        snap_rd  = 1'b0;
        logic        snap_wr  = 1'b0;
        logic [31:0] snap_addr  = 0;
        logic [31:0] snap_wdata = 0;
        logic [3:0]  snap_mbe   = 0;
        logic        got_err    = 1'b0;
        logic [31:0] got_rdata  = 0;
        apply_stimulus(v);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) begin
                snap_rd    = pmem.read;
                snap_wr    = pmem.write;
                snap_addr  = pmem.address;
                snap_wdata = pmem.wdata;
                snap_mbe   = pmem.mbe;
            end
            if (pmem.read || pmem.write) begin
                req_cyc++;
                if ({pmem.read, pmem.write, pmem.address, pmem.wdata, pmem.mbe} !==
                    {snap_rd, snap_wr, snap_addr, snap_wdata, snap_mbe}) begin
                    stable = 1'b0;
                end
            end
            if (cpu.resp) begin
                resp_cyc  = k;
                got_err   = cpu.err;
                got_rdata = cpu.rdata;
                cpu.read  = 1'b0;
                cpu.write = 1'b0;
                pmem.resp = 1'b0;
                break;
            end
            pmem.resp = (k == v.wait_cyc + 1);
        end
        cpu.read  = 1'b0;
        cpu.write = 1'b0;
        pmem.resp = 1'b0;
        @(negedge clk);
        exp_stall = exp_stall + 32'(v.exp_req);
        check_output(idx, v, resp_cyc, got_err, got_rdata, req_cyc, snap_rd, snap_wr,
                     snap_addr, snap_mbe, snap_wdata, stable, cpu.resp, cpu.rdata);
    endtask

`ifdef MEM_PORT_TIMEOUT_EN
    task automatic run_timeout(input string name, input int resp_at, input logic exp_err,
                               input logic [31:0] exp_rdata);
        int          resp_cyc = -1;
        int          req_cyc  = 0;
        logic        got_err  = 1'b0;
        logic [31:0] got_rdata = 0;
        cpu_t.read    = 1'b1;
        cpu_t.address = 32'h0000_0080;
        pmem_t.rdata  = 32'h600D_F00D;
        pmem_t.resp   = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (pmem_t.read) req_cyc++;
            if (cpu_t.resp) begin
                resp_cyc  = k;
                got_err   = cpu_t.err;
                got_rdata = cpu_t.rdata;
                cpu_t.read = 1'b0;
                break;
            end
            pmem_t.resp = (k == resp_at);
        end
        cpu_t.read  = 1'b0;
        pmem_t.resp = 1'b0;
        @(negedge clk);
        check_val({name, " latency"}, resp_cyc, 5);
        check_val({name, " req_cycles"}, req_cyc, 4);
        check_val({name, " cpu_err"}, got_err, exp_err);
        check_val({name, " cpu_rdata"}, got_rdata, exp_rdata);
        check_val({name, " strobe_low"}, pmem_t.read, 1'b0);
    endtask
`endif

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int resp_count;
        int strobe_count;

        vecs[0]  = '{1'b1, 1'b0, 32'h0000_1236, 32'h0, 4'h0, 0, 32'hDEAD_BEEF,
                     1'b1, 1'b0, 32'h0000_1234, 4'hF, 2, 1, 1'b0, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b1, 1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 0, 32'h9999_9999,
                     1'b0, 1'b0, 32'h0, 4'h0, 1, 0, 1'b1, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 4'h0, 1, 32'h0123_4567,
                     1'b1, 1'b0, 32'hFFFF_FFFC, 4'hF, 3, 2, 1'b0, 32'h0123_4567};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0200, 32'h0000_0055, 4'h5, 0, 32'h7777_7777,
                     1'b0, 1'b0, 32'h0, 4'h0, 1, 0, 1'b1, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0041, 32'h0, 4'h3, 0, 32'hCAFE_F00D,
                     1'b1, 1'b0, 32'h0000_0040, 4'hF, 2, 1, 1'b0, 32'hCAFE_F00D};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0100, 32'hABCD_0000, 4'hC, 2, 32'h1111_1111,
                     1'b0, 1'b1, 32'h0000_0100, 4'hC, 4, 3, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_2003, 32'h0000_00AA, 4'h1, 0, 32'h2222_2222,
                     1'b0, 1'b1, 32'h0000_2000, 4'h1, 2, 1, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_3000, 32'h0000_BEEF, 4'h3, 0, 32'h2222_2222,
                     1'b0, 1'b1, 32'h0000_3000, 4'h3, 2, 1, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_3000, 32'h0000_BEEF, 4'h6, 0, 32'h2222_2222,
                     1'b0, 1'b0, 32'h0, 4'h0, 1, 0, 1'b1, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_8000, 32'h0, 4'h0, 19, 32'h5A5A_5A5A,
                     1'b1, 1'b0, 32'h0000_8000, 4'hF, 21, 20, 1'b0, 32'h5A5A_5A5A};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_0013, 32'h7F00_0000, 4'h8, 1, 32'h3333_3333,
                     1'b0, 1'b1, 32'h0000_0010, 4'h8, 3, 2, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 0, 32'h4444_4444,
                     1'b0, 1'b1, 32'h0000_0020, 4'hF, 2, 1, 1'b0, 32'h0};

        rst         = 1'b0;
        cpu.read    = 1'b0;
        cpu.write   = 1'b0;
        cpu.address = 32'h0;
        cpu.wdata   = 32'h0;
        cpu.mbe     = 4'h0;
        pmem.rdata  = 32'h0;
        pmem.resp   = 1'b0;
`ifdef MEM_PORT_TIMEOUT_EN
        cpu_t.read    = 1'b0;
        cpu_t.write   = 1'b0;
        cpu_t.address = 32'h0;
        cpu_t.wdata   = 32'h0;
        cpu_t.mbe     = 4'h0;
        pmem_t.rdata  = 32'h0;
        pmem_t.resp   = 1'b0;
`endif

        repeat (2) @(negedge clk);
        check_val("reset pmem_read", pmem.read, 1'b0);
        check_val("reset pmem_write", pmem.write, 1'b0);
        check_val("reset pmem_address", pmem.address, 32'h0);
        check_val("reset cpu_resp", cpu.resp, 1'b0);
        check_val("reset cpu_err", cpu.err, 1'b0);
        check_val("reset cpu_rdata", cpu.rdata, 32'h0);
        check_val("reset stall_count", stall_count, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_vector(i, vecs[i]);
        end

        // Stray memory responses while idle must not start or finish anything.
        pmem.resp = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_val("idle_resp cpu_resp", cpu.resp, 1'b0);
            check_val("idle_resp strobes", {pmem.read, pmem.write}, 2'b00);
        end
        pmem.resp = 1'b0;
        check_val("idle_resp stall_count", stall_count, exp_stall);

        // Request held into the cycle after DONE is a second, separate access.
        resp_count   = 0;
        strobe_count = 0;
        cpu.read     = 1'b1;
        cpu.address  = 32'h0000_0400;
        pmem.rdata   = 32'h1357_9BDF;
        pmem.resp    = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (cpu.resp) resp_count++;
            if (pmem.read) strobe_count++;
            if (k == 4) cpu.read = 1'b0;
        end
        pmem.resp = 1'b0;
        exp_stall = exp_stall + 32'd2;
        check_val("b2b resp_count", resp_count, 2);
        check_val("b2b access_count", strobe_count, 2);
        check_val("b2b cpu_rdata", cpu.rdata, 32'h1357_9BDF);
        check_val("b2b stall_count", stall_count, exp_stall);

        // Asynchronous reset in the middle of a pending read.
        cpu.read    = 1'b1;
        cpu.address = 32'h0000_0040;
        pmem.resp   = 1'b0;
        repeat (3) @(negedge clk);
        check_val("midreset pre pmem_read", pmem.read, 1'b1);
        #2 rst = 1'b0;
        #1;
        check_val("midreset pmem_read", pmem.read, 1'b0);
        check_val("midreset stall_count", stall_count, 32'h0);
        check_val("midreset stall_small", 32'(stall_small), 32'h0);
        check_val("midreset cpu_resp", cpu.resp, 1'b0);
        cpu.read  = 1'b0;
        exp_stall = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("postreset strobes", {pmem.read, pmem.write}, 2'b00);
        check_val("postreset cpu_resp", cpu.resp, 1'b0);
        run_vector(12, vecs[0]);

`ifdef MEM_PORT_TIMEOUT_EN
        run_timeout("timeout_win", 4, 1'b0, 32'h600D_F00D);
        run_timeout("timeout_err", 0, 1'b1, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
